// File: rtl/slv_arb_pkg.sv
// Shared types and helpers for the slave-channel arbiter: channel ids, lock FSM states
// and the wrap-around first-one search used by both arbitration modes.
package slv_arb_pkg;

    localparam int unsigned SLV_ARB_MAX_CH = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    typedef logic [2:0] ch_id_t;

    // First set bit of req at or after ptr, wrapping n-1 -> 0; returns ptr when req is empty.
    function automatic ch_id_t first_one_from(input logic [SLV_ARB_MAX_CH-1:0] req,
                                              input ch_id_t                    ptr,
                                              input int unsigned               n);
        ch_id_t      result;
        logic        found;
        int unsigned pos;
        result = ptr;
        found  = 1'b0;
        for (int unsigned k = 0; k < SLV_ARB_MAX_CH; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= n) begin
                pos = pos - n;
            end
            if ((k < n) && !found && req[3'(pos)]) begin
                result = ch_id_t'(pos);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // (id + 1) mod n for a valid channel id.
    function automatic ch_id_t wrap_inc(input ch_id_t id, input int unsigned n);
        if (32'(id) + 32'd1 >= n) begin
            return ch_id_t'(0);
        end
        return id + ch_id_t'(1);
    endfunction

endpackage

// File: rtl/slv_chnl_arbiter_if.sv
// Bus bundle around the arbiter: NUM_CH upstream valid/data/ready channels plus the
// single tagged downstream channel. master = arbiter view, slave = surrounding logic.
interface slv_chnl_arbiter_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DW     = 32
);
    localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [IDW-1:0]       out_id;
    logic                 out_ready;

    modport master (
        input  ch_valid,
        input  ch_data,
        output ch_ready,
        output out_valid,
        output out_data,
        output out_id,
        input  out_ready
    );

    modport slave (
        output ch_valid,
        output ch_data,
        input  ch_ready,
        input  out_valid,
        input  out_data,
        input  out_id,
        output out_ready
    );

endinterface

// File: rtl/slv_rr_picker.sv
// Pure-combinational grant picker: fixed priority from channel 0, or round-robin
// starting at ptr. Returns the winner as one-hot (zero when req is empty) and as an index.
module slv_rr_picker
    import slv_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 3
) (
    input  logic [NUM_CH-1:0] req,
    input  ch_id_t            ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] onehot_c,
    output ch_id_t            index_c
);

    always_comb begin
        index_c  = first_one_from(SLV_ARB_MAX_CH'(req), mode ? ptr : ch_id_t'(0), NUM_CH);
        onehot_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ((|req) && (index_c == ch_id_t'(i))) begin
                onehot_c[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slv_chnl_arbiter.sv
// Arbitrates NUM_CH upstream slave channels onto one registered, id-tagged output slot.
// Define SLV_ARB_BURST_LOCK_EN to hold a grant for up to BURST_LEN beats per channel.
module slv_chnl_arbiter
    import slv_arb_pkg::*;
#(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic               rr_mode,
    slv_chnl_arbiter_if.master bus
);

    localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // An out-of-range configuration never grants rather than misbehaving.
    localparam bit CFG_OK = (NUM_CH >= 2) && (NUM_CH <= SLV_ARB_MAX_CH) &&
                            (BURST_LEN >= 1) && (BURST_LEN <= 16);

    logic [NUM_CH-1:0] req_c;
    logic [NUM_CH-1:0] req_arb_c;
    logic [NUM_CH-1:0] grant_onehot_c;
    logic [NUM_CH-1:0] ready_c;
    ch_id_t            grant_idx_c;
    logic              slot_free_c;
    logic              accept_c;
    logic [DW-1:0]     win_data_c;

    ch_id_t            rr_ptr_q;
    ch_id_t            rr_ptr_d;

    logic              out_valid_q;
    logic [DW-1:0]     out_data_q;
    logic [IDW-1:0]    out_id_q;

    assign req_c       = bus.ch_valid & ch_en;
    assign slot_free_c = !out_valid_q || bus.out_ready;
    assign ready_c     = (rstn && CFG_OK && slot_free_c) ? grant_onehot_c : '0;
    assign accept_c    = |(ready_c & bus.ch_valid);

    slv_rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .req      (req_arb_c),
        .ptr      (rr_ptr_q),
        .mode     (rr_mode),
        .onehot_c (grant_onehot_c),
        .index_c  (grant_idx_c)
    );

    // Winning channel's data word.
    always_comb begin
        win_data_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_onehot_c[i]) begin
                win_data_c = bus.ch_data[i*DW +: DW];
            end
        end
    end

`ifdef SLV_ARB_BURST_LOCK_EN
    localparam int unsigned BCW    = $clog2(BURST_LEN + 1);
    localparam logic [0:0]  S_IDLE = 1'(ARB_IDLE);
    localparam logic [0:0]  S_LOCK = 1'(ARB_LOCK);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    ch_id_t            lock_ch_q;
    ch_id_t            lock_ch_d;
    logic [BCW-1:0]    beat_cnt_q;
    logic [BCW-1:0]    beat_cnt_d;
    logic [NUM_CH-1:0] lock_mask_c;
    logic              lock_req_c;

    always_comb begin
        lock_mask_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (lock_ch_q == ch_id_t'(i)) begin
                lock_mask_c[i] = 1'b1;
            end
        end
    end

    assign lock_req_c = |(req_c & lock_mask_c);
    assign req_arb_c  = (state_q == S_LOCK) ? (req_c & lock_mask_c) : req_c;

    // Lock FSM next state; the pointer only moves when a lock is released.
    always_comb begin
        state_d    = state_q;
        lock_ch_d  = lock_ch_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    lock_ch_d  = grant_idx_c;
                    beat_cnt_d = BCW'(1);
                    if (BURST_LEN > 1) begin
                        state_d = S_LOCK;
                    end else if (rr_mode) begin
                        rr_ptr_d = wrap_inc(grant_idx_c, NUM_CH);
                    end
                end
            end
            S_LOCK: begin
                if (accept_c) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (beat_cnt_d == BCW'(BURST_LEN)) begin
                        state_d = S_IDLE;
                        if (rr_mode) begin
                            rr_ptr_d = wrap_inc(lock_ch_q, NUM_CH);
                        end
                    end
                end else if (slot_free_c && !lock_req_c) begin
                    state_d = S_IDLE;
                    if (rr_mode) begin
                        rr_ptr_d = wrap_inc(lock_ch_q, NUM_CH);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            lock_ch_q  <= ch_id_t'(0);
            beat_cnt_q <= '0;
            rr_ptr_q   <= ch_id_t'(0);
        end else begin
            state_q    <= state_d;
            lock_ch_q  <= lock_ch_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end
`else
    assign req_arb_c = req_c;

    // Re-arbitrate every beat; the pointer follows each round-robin winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept_c && rr_mode) begin
            rr_ptr_d = wrap_inc(grant_idx_c, NUM_CH);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= ch_id_t'(0);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Output slot: load on accept, empty on drain, otherwise hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= win_data_c;
            out_id_q    <= IDW'(grant_idx_c);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.ch_ready  = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_slv_chnl_arbiter.sv
// Scoreboard bench for slv_chnl_arbiter: directed steps push the expected tagged word,
// a negedge monitor pops and compares whenever a word leaves the output slot.
module tb_slv_chnl_arbiter;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned DW        = 32;
    localparam int unsigned BURST_LEN = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NUM_CH-1:0] ch_en;
    logic              rr_mode;

    beat_t       sb[$];
    beat_t       held;
    logic [31:0] cur[NUM_CH];
    int          checks = 0;
    int          errors = 0;
    int unsigned stamp  = 0;

    slv_chnl_arbiter_if #(.NUM_CH(NUM_CH), .DW(DW)) bus ();

    slv_chnl_arbiter #(
        .NUM_CH    (NUM_CH),
        .DW        (DW),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ch_en   (ch_en),
        .rr_mode (rr_mode),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word taken downstream must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual id=%0d data=%h required none at %0t",
                         bus.out_id, bus.out_data, $time);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("out_id", 64'(bus.out_id), 64'(e.id));
                check("out_data", 64'(bus.out_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive valid mask and fresh data, check grant, log expected word (-1 = none).
    task automatic step(input logic [NUM_CH-1:0] v, input int exp_id);
        logic [NUM_CH-1:0] exp_rdy;
        bus.ch_valid = v;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cur[i] = {4'(i + 1), 12'hABC, 16'(stamp)};
            bus.ch_data[i*DW +: DW] = cur[i];
        end
        stamp++;
        #1;
        exp_rdy = (exp_id >= 0) ? NUM_CH'(1 << exp_id) : '0;
        check("ch_ready", 64'(bus.ch_ready), 64'(exp_rdy));
        if (exp_id >= 0) begin
            sb.push_back({2'(exp_id), cur[exp_id]});
        end
        tick();
    endtask

    task automatic do_reset();
        bus.ch_valid = '0;
        check("sb_drained", 64'(sb.size()), 64'd0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

`ifdef SLV_ARB_BURST_LOCK_EN
    int exp_rr[6]    = '{0, 0, 0, 0, 1, 1};
    int exp_fix[6]   = '{0, 0, 0, -1, 1, 1};
    int exp_en101[4] = '{0, 0, 0, 0};
`else
    int exp_rr[6]    = '{0, 1, 2, 0, 1, 2};
    int exp_fix[6]   = '{0, 0, 0, 1, 1, 1};
    int exp_en101[4] = '{0, 2, 0, 2};
`endif

    initial begin
        rstn          = 1'b0;
        ch_en         = 3'b111;
        rr_mode       = 1'b0;
        bus.ch_valid  = 3'b111;
        bus.ch_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_id", 64'(bus.out_id), 64'd0);
        check("rst_ch_ready", 64'(bus.ch_ready), 64'd0);
        bus.ch_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single word from ch0, one-cycle latency.
        bus.ch_valid = 3'b001;
        bus.ch_data  = {32'h0, 32'h0, 32'hA5A5_0000};
        #1;
        check("t1_ch_ready", 64'(bus.ch_ready), 64'd1);
        sb.push_back({2'd0, 32'hA5A5_0000});
        tick();
        check("t1_latency_valid", 64'(bus.out_valid), 64'd1);
        step(3'b000, -1);

        // Round-robin, all channels valid.
        do_reset();
        rr_mode = 1'b1;
        for (int k = 0; k < 6; k++) step(3'b111, exp_rr[k]);
        step(3'b000, -1);

        // Fixed priority; ch0 drops after three beats.
        do_reset();
        rr_mode = 1'b0;
        for (int k = 0; k < 6; k++) step((k < 3) ? 3'b111 : 3'b110, exp_fix[k]);
        step(3'b000, -1);

        // Downstream stall for five cycles with a word held.
        do_reset();
        bus.out_ready = 1'b0;
        step(3'b001, 0);
        held = sb[sb.size()-1];
        for (int k = 0; k < 5; k++) begin
            bus.ch_valid = 3'b001;
            bus.ch_data[DW-1:0] = 32'hDEAD_0000 + 32'(k);
            #1;
            check("stall_ch_ready", 64'(bus.ch_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out_data", 64'(bus.out_data), 64'(held.data));
            check("stall_out_id", 64'(bus.out_id), 64'(held.id));
            tick();
        end
        bus.out_ready = 1'b1;
        step(3'b001, 0);
        step(3'b000, -1);

        // ch1 disabled, then asynchronous reset mid-stream.
        do_reset();
        ch_en   = 3'b101;
        rr_mode = 1'b1;
        for (int k = 0; k < 4; k++) step(3'b111, exp_en101[k]);
        bus.ch_valid = 3'b111;
        #1;
        rstn = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_out_data", 64'(bus.out_data), 64'd0);
        check("async_rst_out_id", 64'(bus.out_id), 64'd0);
        check("async_rst_ch_ready", 64'(bus.ch_ready), 64'd0);
        sb.delete();
        bus.ch_valid = '0;
        @(negedge clk);
        #1;
        rstn = 1'b1;
        tick();
        ch_en = 3'b111;
        step(3'b111, 0);
        step(3'b000, -1);

`ifdef SLV_ARB_BURST_LOCK_EN
        // Burst lock: four beats per grant, then early release when the owner drops.
        do_reset();
        rr_mode = 1'b1;
        for (int k = 0; k < 8; k++) step(3'b011, (k < 4) ? 0 : 1);
        step(3'b000, -1);
        do_reset();
        step(3'b011, 0);
        step(3'b011, 0);
        step(3'b010, -1);
        step(3'b010, 1);
        step(3'b010, 1);
        step(3'b000, -1);
`endif

        tick();
        tick();
        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
